mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single unified memory between instruction fetch (port I) and data load/store (port D) in the multicycle MIPS core.
- Absorbs the memory's fixed read latency, so the main controller no longer sequences memory wait states itself.
- Each port gets a request/done handshake with a registered read-data result.
- Sits between the controller/datapath (PC/IR path and ALU-out/MDR path) and the memory.

Parameters:
AW, 32, address width in bits
DW, 32, data width in bits
LAT, 2, memory read latency in cycles from address valid to Mem_RData valid; legal range 1..15

Ports:
Clock  in  1  system clock, rising-edge
Reset  in  1  synchronous, active-high reset
I_Req  in  1  fetch request
I_Addr  in  AW  fetch address
I_Done  out  1  one-cycle pulse: fetch complete, I_RData valid
I_RData  out  DW  fetched word, held until the next fetch completes
D_Req  in  1  data request
D_Wr  in  1  1=store, 0=load; sampled with D_Req
D_Addr  in  AW  data address
D_WData  in  DW  store data
D_Done  out  1  one-cycle pulse: data access complete
D_RData  out  DW  loaded word, held until the next load completes
Mem_Addr  out  AW  memory address (registered)
Mem_WData  out  DW  memory write data (registered)
Mem_Wr  out  1  memory write strobe, exactly one cycle per store
Mem_RData  in  DW  memory read data
Busy  out  1  1 in any state other than IDLE
Sel  out  1  owner of the current access: 0=I, 1=D

Behaviour:
- Reset (synchronous, wins over everything):
  - State to IDLE.
  - All outputs to 0, including I_RData, D_RData, Mem_Addr and Mem_WData.
  - Latency counter to 0; last-served register to I.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Requests are sampled only in this state.
  - No request: stay in IDLE.
  - Otherwise grant per the priority rule and go to ISSUE.
  - On the grant edge, latch into Mem_Addr, Mem_WData, Sel and an internal write flag: granted address, D_WData (stores only) and D_Wr (D only; always 0 for I).
- ISSUE (cycle t0+1, where t0 is the IDLE cycle that saw the request):
  - Mem_Addr is valid.
  - Store: Mem_Wr=1 for this cycle only; next state DONE.
  - Load or fetch: load counter with LAT-1; next state WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, capture Mem_RData on this edge into I_RData or D_RData (per Sel), then go to DONE.
  - With LAT=1, WAIT lasts one cycle.
- DONE:
  - I_Done or D_Done (per Sel) = 1 for exactly one cycle.
  - Update last-served to Sel; next state IDLE.
- Latency, request seen at t0 to Done asserted:
  - Read: LAT+2 cycles (t0+4 at LAT=2).
  - Store: 2 cycles.
- Back-to-back minimum issue interval: Done cycle, then IDLE, then the next ISSUE.
- Hold rules:
  - Mem_Addr, Mem_WData and Sel hold their last value outside ISSUE/WAIT/DONE.
  - Mem_Wr is 0 in every state except ISSUE for a store.
- Requester contract:
  - Hold Req until Done, and drop it in the cycle after Done unless another access is wanted.
  - A Req still high in IDLE starts a new access.
  - Addr/Wr/WData inputs are ignored outside IDLE.
- Priority (default): D wins when I_Req and D_Req are both high in IDLE. This lets a load/store finish before the next fetch.
- A losing request stays pending and is granted in the next IDLE visit.
- Reset during ISSUE/WAIT/DONE:
  - Abort the access; no Done pulse, Mem_Wr=0 on the next cycle.
  - Captured read data clears to 0.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: on simultaneous I_Req/D_Req in IDLE, grant the port that is not last-served (round-robin).
  - last-served resets to I, so the first tie goes to D and the next tie goes to I.
  - A single requester is always granted regardless of last-served.
- Undefined: fixed D priority; the last-served register may be optimised away.

Test Plan:
- Fetch, LAT=2, memory word 0x40 = 0x8C220004; I_Req=1, I_Addr=0x40 at t0 -> Mem_Addr=0x40 at t0+1; I_Done=1 only at t0+4; I_RData=0x8C220004; Busy low at t0+5.
- Store: D_Req=1, D_Wr=1, D_Addr=0x100, D_WData=0xDEADBEEF at t0 -> Mem_Wr=1 only at t0+1 with Mem_Addr=0x100 and Mem_WData=0xDEADBEEF; D_Done at t0+2; I_Done stays 0.
- Tie: I_Req and D_Req both high, default build -> D served first (Sel=1, D_Done at t0+4); I served next (I_Done at t0+9). With MEM_ARB_RR_EN and both held high for 4 accesses -> grant order D, I, D, I.
- LAT=1 build, load from 0x20 holding 0x12345678 -> D_Done at t0+3; D_RData=0x12345678.
- Reset asserted at t0+2 of a load -> no D_Done ever pulses; all outputs 0 at t0+3; Busy=0; a new I_Req is serviced normally afterwards.
- D_Addr changed during WAIT -> Mem_Addr unchanged; D_RData equals the data at the originally latched address.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a fixed-latency unified memory.
// Optional macro MEM_ARB_RR_EN: round-robin on simultaneous requests instead of fixed D priority.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          I_Req,
  input  logic [AW-1:0] I_Addr,
  output logic          I_Done,
  output logic [DW-1:0] I_RData,
  input  logic          D_Req,
  input  logic          D_Wr,
  input  logic [AW-1:0] D_Addr,
  input  logic [DW-1:0] D_WData,
  output logic          D_Done,
  output logic [DW-1:0] D_RData,
  output logic [AW-1:0] Mem_Addr,
  output logic [DW-1:0] Mem_WData,
  output logic          Mem_Wr,
  input  logic [DW-1:0] Mem_RData,
  output logic          Busy,
  output logic          Sel,
  output logic [1:0]    Dbg_State
);

  // Handshake: a requester holds Req high until its one-cycle Done pulse; requests
  // are only sampled in IDLE, so Addr/Wr/WData are don't-care while an access runs.

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q;
  logic          wr_q;
  logic          sel_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] i_rdata_q;
  logic [DW-1:0] d_rdata_q;
  logic          grant_d;

`ifdef MEM_ARB_RR_EN
  logic last_q;
  // A tie goes to whichever port was not served last; a lone requester always wins.
  assign grant_d = D_Req & (~I_Req | ~last_q);
`else
  assign grant_d = D_Req;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (I_Req | D_Req) state_d = S_ISSUE;
      S_ISSUE: state_d = wr_q ? S_DONE : S_WAIT;
      S_WAIT:  if (cnt_q == 4'd0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      sel_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
`ifdef MEM_ARB_RR_EN
      last_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (I_Req | D_Req) begin
            sel_q      <= grant_d;
            mem_addr_q <= grant_d ? D_Addr : I_Addr;
            wr_q       <= grant_d & D_Wr;
            if (grant_d & D_Wr) mem_wdata_q <= D_WData;
          end
        end
        S_ISSUE: cnt_q <= LAT_M1;
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            if (sel_q) d_rdata_q <= Mem_RData;
            else       i_rdata_q <= Mem_RData;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_DONE: begin
`ifdef MEM_ARB_RR_EN
          last_q <= sel_q;
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    Busy   = (state_q != S_IDLE);
    Mem_Wr = (state_q == S_ISSUE) & wr_q;
    I_Done = (state_q == S_DONE) & ~sel_q;
    D_Done = (state_q == S_DONE) & sel_q;
  end

  assign Mem_Addr  = mem_addr_q;
  assign Mem_WData = mem_wdata_q;
  assign Sel       = sel_q;
  assign I_RData   = i_rdata_q;
  assign D_RData   = d_rdata_q;
  assign Dbg_State = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a LAT=2 instance (main) and a LAT=1 instance (short path).
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  // LAT=2 instance signals
  logic        a_i_req, a_d_req, a_d_wr;
  logic [31:0] a_i_addr, a_d_addr, a_d_wdata;
  logic        a_i_done, a_d_done, a_mem_wr, a_busy, a_sel;
  logic [31:0] a_i_rdata, a_d_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [1:0]  a_state;

  // LAT=1 instance signals
  logic        b_d_req;
  logic [31:0] b_d_addr;
  logic        b_i_done, b_d_done, b_mem_wr, b_busy, b_sel;
  logic [31:0] b_i_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [1:0]  b_state;

  mem_arbiter #(.AW(32), .DW(32), .LAT(2)) u_a (
    .Clock(clk), .Reset(Reset),
    .I_Req(a_i_req), .I_Addr(a_i_addr), .I_Done(a_i_done), .I_RData(a_i_rdata),
    .D_Req(a_d_req), .D_Wr(a_d_wr), .D_Addr(a_d_addr), .D_WData(a_d_wdata),
    .D_Done(a_d_done), .D_RData(a_d_rdata),
    .Mem_Addr(a_mem_addr), .Mem_WData(a_mem_wdata), .Mem_Wr(a_mem_wr), .Mem_RData(a_mem_rdata),
    .Busy(a_busy), .Sel(a_sel), .Dbg_State(a_state)
  );

  mem_arbiter #(.AW(32), .DW(32), .LAT(1)) u_b (
    .Clock(clk), .Reset(Reset),
    .I_Req(1'b0), .I_Addr(32'h0), .I_Done(b_i_done), .I_RData(b_i_rdata),
    .D_Req(b_d_req), .D_Wr(1'b0), .D_Addr(b_d_addr), .D_WData(32'h0),
    .D_Done(b_d_done), .D_RData(b_d_rdata),
    .Mem_Addr(b_mem_addr), .Mem_WData(b_mem_wdata), .Mem_Wr(b_mem_wr), .Mem_RData(b_mem_rdata),
    .Busy(b_busy), .Sel(b_sel), .Dbg_State(b_state)
  );

  // Memory model: preloaded words plus a write-back store, read through a LAT-deep pipe.
  logic [31:0]  mem [256];
  logic [255:0] written;
  logic [31:0]  a_rd1, a_rd2, b_rd1;

  function automatic logic [31:0] init_word(input logic [31:0] addr);
    case (addr)
      32'h40:  return 32'h8C220004;
      32'h20:  return 32'h12345678;
      32'h80:  return 32'h11111111;
      32'h84:  return 32'h22222222;
      default: return addr ^ 32'hA5A50000;
    endcase
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] addr);
    return written[addr[9:2]] ? mem[addr[9:2]] : init_word(addr);
  endfunction

  always @(posedge clk) begin
    if (Reset) written <= '0;
    else if (a_mem_wr) begin
      mem[a_mem_addr[9:2]]     <= a_mem_wdata;
      written[a_mem_addr[9:2]] <= 1'b1;
    end
    a_rd1 <= mem_rd(a_mem_addr);
    a_rd2 <= a_rd1;
    b_rd1 <= mem_rd(b_mem_addr);
  end
  assign a_mem_rdata = a_rd2;
  assign b_mem_rdata = b_rd1;

  int n_checks = 0;
  int n_pass   = 0;
  logic exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output logic gi, output logic gd);
    gi = 1'b0;
    gd = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (a_i_done | a_d_done) begin
        gi = a_i_done;
        gd = a_d_done;
        return;
      end
    end
    check("done_timeout", 64'd1, 64'd0);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
  endtask

  logic gi, gd, exp_sel;

  initial begin
    Reset = 1'b1;
    a_i_req = 0; a_d_req = 0; a_d_wr = 0;
    a_i_addr = 0; a_d_addr = 0; a_d_wdata = 0;
    b_d_req = 0; b_d_addr = 0;
    step();
    step();
    check("rst_busy", a_busy, 0);
    check("rst_mem_addr", a_mem_addr, 0);
    check("rst_mem_wr", a_mem_wr, 0);
    check("rst_state", a_state, 0);
    Reset = 1'b0;

    // Fetch at LAT=2: done at t0+4
    a_i_req = 1; a_i_addr = 32'h40;
    step();
    check("fetch_addr_t1", a_mem_addr, 32'h40);
    check("fetch_busy_t1", a_busy, 1);
    check("fetch_sel_t1", a_sel, 0);
    step();
    check("fetch_done_t2", a_i_done, 0);
    step();
    check("fetch_done_t3", a_i_done, 0);
    step();
    check("fetch_done_t4", a_i_done, 1);
    check("fetch_rdata", a_i_rdata, 32'h8C220004);
    a_i_req = 0;
    step();
    check("fetch_busy_t5", a_busy, 0);
    check("fetch_done_t5", a_i_done, 0);

    // Store: Mem_Wr only at t0+1, done at t0+2
    a_d_req = 1; a_d_wr = 1; a_d_addr = 32'h100; a_d_wdata = 32'hDEADBEEF;
    step();
    check("st_wr_t1", a_mem_wr, 1);
    check("st_addr_t1", a_mem_addr, 32'h100);
    check("st_wdata_t1", a_mem_wdata, 32'hDEADBEEF);
    check("st_sel_t1", a_sel, 1);
    step();
    check("st_wr_t2", a_mem_wr, 0);
    check("st_ddone_t2", a_d_done, 1);
    check("st_idone_t2", a_i_done, 0);
    a_d_req = 0; a_d_wr = 0;
    step();
    check("st_mem", mem_rd(32'h100), 32'hDEADBEEF);

    // Tie after reset: D first (done t0+4), then I (done t0+9)
    do_reset();
    a_i_req = 1; a_i_addr = 32'h40;
    a_d_req = 1; a_d_addr = 32'h80;
    step();
    check("tie_sel_t1", a_sel, 1);
    step(); step(); step();
    check("tie_ddone_t4", a_d_done, 1);
    check("tie_drdata", a_d_rdata, 32'h11111111);
    a_d_req = 0;
    step();
    check("tie_busy_t5", a_busy, 0);
    step();
    check("tie_sel_t6", a_sel, 0);
    check("tie_addr_t6", a_mem_addr, 32'h40);
    step(); step();
    check("tie_idone_t8", a_i_done, 0);
    step();
    check("tie_idone_t9", a_i_done, 1);
    a_i_req = 0;
    step();

    // Four accesses with both requesters held high
`ifdef MEM_ARB_RR_EN
    exp_q = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_q = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    a_i_req = 1; a_d_req = 1;
    for (int n = 0; n < 4; n++) begin
      wait_done(gi, gd);
      exp_sel = exp_q.pop_front();
      check("rr_d_done", gd, exp_sel);
      check("rr_i_done", gi, !exp_sel);
      if (gd) check("rr_drdata", a_d_rdata, 32'h11111111);
      else    check("rr_irdata", a_i_rdata, 32'h8C220004);
    end
    a_i_req = 0; a_d_req = 0;
    step(); step();

    // Reset at t0+2 of a load aborts it
    a_d_req = 1; a_d_addr = 32'h40;
    step();
    step();
    Reset = 1; a_d_req = 0;
    step();
    Reset = 0;
    check("abort_busy", a_busy, 0);
    check("abort_ddone", a_d_done, 0);
    check("abort_mem_wr", a_mem_wr, 0);
    check("abort_mem_addr", a_mem_addr, 0);
    check("abort_mem_wdata", a_mem_wdata, 0);
    check("abort_drdata", a_d_rdata, 0);
    check("abort_irdata", a_i_rdata, 0);
    check("abort_sel", a_sel, 0);
    gd = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      gd = gd | a_d_done;
    end
    check("abort_no_ddone", gd, 0);
    a_i_req = 1; a_i_addr = 32'h40;
    wait_done(gi, gd);
    check("post_abort_idone", gi, 1);
    check("post_abort_irdata", a_i_rdata, 32'h8C220004);
    a_i_req = 0;
    step();

    // D_Addr changes during WAIT are ignored
    a_d_req = 1; a_d_addr = 32'h80;
    step();
    a_d_addr = 32'h84;
    step();
    check("addr_hold", a_mem_addr, 32'h80);
    wait_done(gi, gd);
    check("addr_hold_done", gd, 1);
    check("addr_hold_rdata", a_d_rdata, 32'h11111111);
    a_d_req = 0;
    step();

    // LAT=1 load: done at t0+3
    b_d_req = 1; b_d_addr = 32'h20;
    step();
    check("lat1_addr_t1", b_mem_addr, 32'h20);
    step();
    check("lat1_done_t2", b_d_done, 0);
    step();
    check("lat1_done_t3", b_d_done, 1);
    check("lat1_rdata", b_d_rdata, 32'h12345678);
    check("lat1_idone", b_i_done, 0);
    b_d_req = 0;
    step();
    check("lat1_busy_t4", b_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
